cl_frame_desc_gen: RTL and testbench

- Successor to the single-frame CL header analyser. Inspects the header of each incoming cache line (CL), passes data straight through, and accumulates frame length in STs.
- Pushes one descriptor per completed AFU frame into an internal descriptor queue. Several frames can be outstanding, so the input stream does not stall while the downstream reader drains earlier frames.
- Sits between the CL receive path and the AFU frame buffer/reader.

---
 rtl/cl_frame_desc_gen.sv | 197 +++++++++++++++++++
 tb/tb_cl_frame_desc_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_frame_desc_gen.sv
// Purpose : CL frame analyser; passes cache lines through, sums per-CL ST counts and queues one descriptor per frame.
// Latency : data/sof/eof are combinational pass-through; a descriptor is visible one cycle after its closing beat.
// Backpres: sink_ready drops the cycle after the descriptor queue fills and rises the cycle after the first pop.
//
// Ports:
//   clk, rst_sync               clock, synchronous active-high reset
//   sink_data/valid/ready       input cache-line stream
//   source_data/valid/sof/eof   pass-through stream with frame markers
//   desc_valid/ready            descriptor queue head handshake
//   desc_len/ncl/err            head descriptor: STs, CLs, error flag
//   frm_cnt, err_cnt            closed frames (wraps), errored frames (saturates)
//   seq_err                     only with CL_SEQ_CHK_EN: pulse on a mismatching SOF sequence number
//
// Build option: define CL_SEQ_CHK_EN to enable 4-bit frame sequence checking in header bits [EOF_BIT+4:EOF_BIT+1].
module cl_frame_desc_gen #(
    parameter int CL         = 512,
    parameter int EOF_BIT    = 506,
    parameter int LEN_MSB    = 505,
    parameter int LEN_LSB    = 496,
    parameter int W_LEN      = 16,
    parameter int W_NCL      = 11,
    parameter int MAX_CL     = 1024,
    parameter int DESC_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_sync,
    input  logic [CL-1:0]     sink_data,
    input  logic              sink_valid,
    output logic              sink_ready,
    output logic [CL-1:0]     source_data,
    output logic              source_valid,
    output logic              source_sof,
    output logic              source_eof,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [W_LEN-1:0]  desc_len,
    output logic [W_NCL-1:0]  desc_ncl,
    output logic              desc_err,
    output logic [15:0]       frm_cnt,
    output logic [15:0]       err_cnt
`ifdef CL_SEQ_CHK_EN
    ,
    output logic              seq_err
`endif
);

    localparam int AW    = $clog2(DESC_DEPTH);
    localparam int CW    = AW + 1;
    localparam int W_SUM = W_LEN + 1;

    typedef enum logic {IDLE, FRAME} state_t;

    state_t             state;
    logic [W_LEN-1:0]   len_acc;
    logic [W_NCL-1:0]   ncl;
    logic               err_acc;

    logic [W_LEN-1:0]   q_len [DESC_DEPTH];
    logic [W_NCL-1:0]   q_ncl [DESC_DEPTH];
    logic               q_err [DESC_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      q_cnt;

    logic               accept;
    logic               first;
    logic [W_LEN-1:0]   len_base;
    logic [W_NCL-1:0]   ncl_base;
    logic               err_base;
    logic [W_SUM-1:0]   len_sum;
    logic               len_ovf;
    logic [W_LEN-1:0]   len_next;
    logic [W_NCL-1:0]   ncl_next;
    logic               eof_flag;
    logic               hit_max;
    logic               forced;
    logic               closing;
    logic               seq_bad;
    logic               err_next;
    logic               push;
    logic               pop;

    // Ready depends only on reset and the registered count, never on sink_valid.
    assign sink_ready = !rst_sync && (q_cnt < CW'(DESC_DEPTH));
    assign accept     = sink_valid & sink_ready;
    assign first      = (state == IDLE);

    // A new frame starts from zero regardless of accumulator contents.
    assign len_base = first ? '0 : len_acc;
    assign ncl_base = first ? '0 : ncl;
    assign err_base = first ? 1'b0 : err_acc;

    assign len_sum  = {1'b0, len_base} + W_SUM'(sink_data[LEN_MSB:LEN_LSB]);
    assign len_ovf  = len_sum[W_LEN];
    assign len_next = len_ovf ? '1 : len_sum[W_LEN-1:0];
    assign ncl_next = ncl_base + W_NCL'(1);

    assign eof_flag = sink_data[EOF_BIT];
    assign hit_max  = (ncl_next == W_NCL'(MAX_CL));
    // A frame that ends with EOF exactly on the CL limit is a normal close, not an error.
    assign forced   = hit_max & ~eof_flag;
    assign closing  = eof_flag | hit_max;

`ifdef CL_SEQ_CHK_EN
    logic [3:0] seq_exp;
    logic [3:0] seq_cur;
    logic [3:0] seq_rx;
    assign seq_rx  = sink_data[EOF_BIT+4:EOF_BIT+1];
    assign seq_bad = first & (seq_rx != seq_exp);
    assign seq_err = accept & seq_bad;
`else
    assign seq_bad = 1'b0;
`endif

    assign err_next = err_base | len_ovf | forced | seq_bad;
    assign push     = accept & closing;
    assign desc_valid = (q_cnt != '0);
    assign pop      = desc_valid & desc_ready;

    assign source_data  = sink_data;
    assign source_valid = accept;
    assign source_sof   = accept & first;
    assign source_eof   = accept & closing;

    // Head entry is gated so the outputs read zero whenever the queue is empty.
    assign desc_len = desc_valid ? q_len[rd_ptr] : '0;
    assign desc_ncl = desc_valid ? q_ncl[rd_ptr] : '0;
    assign desc_err = desc_valid ? q_err[rd_ptr] : 1'b0;

    // Queue storage needs no reset: it is only visible through the gated head.
    always_ff @(posedge clk) begin
        if (push) begin
            q_len[wr_ptr] <= len_next;
            q_ncl[wr_ptr] <= ncl_next;
            q_err[wr_ptr] <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state   <= IDLE;
            len_acc <= '0;
            ncl     <= '0;
            err_acc <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_cnt   <= '0;
            frm_cnt <= '0;
            err_cnt <= '0;
`ifdef CL_SEQ_CHK_EN
            seq_exp <= '0;
            seq_cur <= '0;
`endif
        end else begin
            if (accept) begin
                if (closing) begin
                    state   <= IDLE;
                    len_acc <= '0;
                    ncl     <= '0;
                    err_acc <= 1'b0;
                end else begin
                    state   <= FRAME;
                    len_acc <= len_next;
                    ncl     <= ncl_next;
                    err_acc <= err_next;
                end
            end

            if (push) begin
                wr_ptr  <= wr_ptr + AW'(1);
                frm_cnt <= frm_cnt + 16'd1;
                if (err_next && (err_cnt != 16'hFFFF))
                    err_cnt <= err_cnt + 16'd1;
            end

            if (pop)
                rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + CW'(1);
                2'b01:   q_cnt <= q_cnt - CW'(1);
                default: q_cnt <= q_cnt;
            endcase

`ifdef CL_SEQ_CHK_EN
            // Expected sequence follows the received SOF value, which resyncs after a mismatch.
            if (accept) begin
                if (first)
                    seq_cur <= seq_rx;
                if (closing)
                    seq_exp <= (first ? seq_rx : seq_cur) + 4'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_cl_frame_desc_gen.sv
module tb_cl_frame_desc_gen;

    logic         clk;
    logic         rst_sync;
    logic [511:0] sink_data;
    logic         sink_valid;
    logic         sink_ready;
    logic [511:0] source_data;
    logic         source_valid;
    logic         source_sof;
    logic         source_eof;
    logic         desc_valid;
    logic         desc_ready;
    logic [15:0]  desc_len;
    logic [10:0]  desc_ncl;
    logic         desc_err;
    logic [15:0]  frm_cnt;
    logic [15:0]  err_cnt;
`ifdef CL_SEQ_CHK_EN
    logic         seq_err;
`endif

    int nvec;
    int nmis;
    logic [3:0] tb_seq;

    cl_frame_desc_gen dut (
        .clk          (clk),
        .rst_sync     (rst_sync),
        .sink_data    (sink_data),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .source_data  (source_data),
        .source_valid (source_valid),
        .source_sof   (source_sof),
        .source_eof   (source_eof),
        .desc_valid   (desc_valid),
        .desc_ready   (desc_ready),
        .desc_len     (desc_len),
        .desc_ncl     (desc_ncl),
        .desc_err     (desc_err),
        .frm_cnt      (frm_cnt),
        .err_cnt      (err_cnt)
`ifdef CL_SEQ_CHK_EN
        ,
        .seq_err      (seq_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] mk_cl(input logic eof, input logic [9:0] len, input logic [3:0] seq);
        logic [511:0] d;
        d = {16{32'h1234_5678}};
        d[510:496] = '0;
        d[510:507] = seq;
        d[506]     = eof;
        d[505:496] = len;
        return d;
    endfunction

    // One beat, entered between edges; returns combinational markers seen during the beat.
    task automatic drive(input logic [511:0] d, input logic last,
                         output logic sof, output logic eof, output logic rdy, output logic [511:0] sd);
        sink_data  = d;
        sink_valid = 1'b1;
        #1;
        sof = source_sof;
        eof = source_eof;
        rdy = sink_ready;
        sd  = source_data;
        @(posedge clk); #1;
        sink_valid = 1'b0;
        if (last) tb_seq = tb_seq + 4'd1;
    endtask

    task automatic pop_one();
        desc_ready = 1'b1;
        @(posedge clk); #1;
        desc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_sync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (sink_ready !== 1'b0) begin nmis++; $display("FAIL rst_ready: got %b want 0", sink_ready); end
        nvec++; if (desc_valid !== 1'b0) begin nmis++; $display("FAIL rst_dvalid: got %b want 0", desc_valid); end
        nvec++; if ({desc_len, desc_ncl, desc_err} !== 28'd0) begin nmis++; $display("FAIL rst_desc: got %0d/%0d/%b want 0/0/0", desc_len, desc_ncl, desc_err); end
        nvec++; if ({frm_cnt, err_cnt} !== 32'd0) begin nmis++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", frm_cnt, err_cnt); end
        rst_sync = 1'b0;
        tb_seq = 4'd0;
        #1;
        nvec++; if (sink_ready !== 1'b1) begin nmis++; $display("FAIL rst_release_ready: got %b want 1", sink_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_multi_cl();
        logic s1, e1, s3, e3, r;
        logic [511:0] sd, d1;
        d1 = mk_cl(1'b0, 10'd31, tb_seq);
        drive(d1, 1'b0, s1, e1, r, sd);
        nvec++; if (sd !== d1) begin nmis++; $display("FAIL multi_passthru: got %h want %h", sd[511:448], d1[511:448]); end
        nvec++; if ({s1, e1} !== 2'b10) begin nmis++; $display("FAIL multi_beat1_sofeof: got %b want 10", {s1, e1}); end
        drive(mk_cl(1'b0, 10'd31, 4'd0), 1'b0, s3, e3, r, sd);
        nvec++; if (desc_valid !== 1'b0) begin nmis++; $display("FAIL multi_early_desc: got %b want 0", desc_valid); end
        drive(mk_cl(1'b1, 10'd10, 4'd0), 1'b1, s3, e3, r, sd);
        nvec++; if ({s3, e3} !== 2'b01) begin nmis++; $display("FAIL multi_beat3_sofeof: got %b want 01", {s3, e3}); end
        nvec++; if (desc_valid !== 1'b1) begin nmis++; $display("FAIL multi_dvalid: got %b want 1", desc_valid); end
        nvec++; if (desc_len !== 16'd72) begin nmis++; $display("FAIL multi_len: got %0d want 72", desc_len); end
        nvec++; if (desc_ncl !== 11'd3) begin nmis++; $display("FAIL multi_ncl: got %0d want 3", desc_ncl); end
        nvec++; if (desc_err !== 1'b0) begin nmis++; $display("FAIL multi_err: got %b want 0", desc_err); end
        nvec++; if (frm_cnt !== 16'd1) begin nmis++; $display("FAIL multi_frm_cnt: got %0d want 1", frm_cnt); end
        pop_one();
        nvec++; if (desc_valid !== 1'b0) begin nmis++; $display("FAIL multi_pop: got %b want 0", desc_valid); end
    endtask

    task automatic test_single();
        logic s, e, r;
        logic [511:0] sd;
        drive(mk_cl(1'b1, 10'd5, tb_seq), 1'b1, s, e, r, sd);
        nvec++; if ({s, e} !== 2'b11) begin nmis++; $display("FAIL single_sofeof: got %b want 11", {s, e}); end
        nvec++; if ({desc_len, desc_ncl} !== {16'd5, 11'd1}) begin nmis++; $display("FAIL single_desc: got %0d/%0d want 5/1", desc_len, desc_ncl); end
        nvec++; if (frm_cnt !== 16'd2) begin nmis++; $display("FAIL single_frm_cnt: got %0d want 2", frm_cnt); end
        pop_one();
        // FSM stayed IDLE, so the next beat must be a start of frame.
        drive(mk_cl(1'b1, 10'd6, tb_seq), 1'b1, s, e, r, sd);
        nvec++; if (s !== 1'b1) begin nmis++; $display("FAIL single_idle_sof: got %b want 1", s); end
        pop_one();
    endtask

    task automatic test_back_to_back();
        logic s, e, r;
        logic [511:0] sd;
        desc_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(mk_cl(1'b1, 10'(i), tb_seq), 1'b1, s, e, r, sd);
            nvec++; if (r !== 1'b1) begin nmis++; $display("FAIL b2b_ready_%0d: got %b want 1", i, r); end
        end
        nvec++; if (sink_ready !== 1'b0) begin nmis++; $display("FAIL b2b_full_ready: got %b want 0", sink_ready); end
        sink_data  = mk_cl(1'b1, 10'd5, tb_seq);
        sink_valid = 1'b1;
        #1;
        nvec++; if (source_valid !== 1'b0) begin nmis++; $display("FAIL b2b_held_valid: got %b want 0", source_valid); end
        @(posedge clk); #1;
        nvec++; if ({frm_cnt, desc_len} !== {16'd7, 16'd1}) begin nmis++; $display("FAIL b2b_held_state: got %0d/%0d want 7/1", frm_cnt, desc_len); end
        desc_ready = 1'b1;
        @(posedge clk); #1;
        desc_ready = 1'b0;
        nvec++; if ({sink_ready, source_valid} !== 2'b11) begin nmis++; $display("FAIL b2b_reopen: got %b want 11", {sink_ready, source_valid}); end
        @(posedge clk); #1;
        sink_valid = 1'b0;
        tb_seq = tb_seq + 4'd1;
        nvec++; if (frm_cnt !== 16'd8) begin nmis++; $display("FAIL b2b_frm_cnt: got %0d want 8", frm_cnt); end
        for (int k = 2; k <= 5; k++) begin
            nvec++; if ({desc_valid, desc_len, desc_ncl} !== {1'b1, 16'(k), 11'd1}) begin nmis++; $display("FAIL b2b_order_%0d: got %b/%0d/%0d want 1/%0d/1", k, desc_valid, desc_len, desc_ncl, k); end
            pop_one();
        end
        nvec++; if (desc_valid !== 1'b0) begin nmis++; $display("FAIL b2b_drained: got %b want 0", desc_valid); end
    endtask

    task automatic test_forced_close();
        logic s, e, r, s1, e_last;
        logic [511:0] sd;
        s1 = 1'b0;
        e_last = 1'b0;
        for (int i = 1; i <= 1024; i++) begin
            drive(mk_cl(1'b0, 10'd1, tb_seq), i == 1024, s, e, r, sd);
            if (i == 1) s1 = s;
            if (i == 1024) e_last = e;
        end
        nvec++; if (s1 !== 1'b1) begin nmis++; $display("FAIL forced_sof: got %b want 1", s1); end
        nvec++; if (e_last !== 1'b1) begin nmis++; $display("FAIL forced_eof: got %b want 1", e_last); end
        nvec++; if ({desc_len, desc_ncl, desc_err} !== {16'd1024, 11'd1024, 1'b1}) begin nmis++; $display("FAIL forced_desc: got %0d/%0d/%b want 1024/1024/1", desc_len, desc_ncl, desc_err); end
        nvec++; if ({frm_cnt, err_cnt} !== {16'd9, 16'd1}) begin nmis++; $display("FAIL forced_cnt: got %0d/%0d want 9/1", frm_cnt, err_cnt); end
        pop_one();
        drive(mk_cl(1'b1, 10'd0, tb_seq), 1'b1, s, e, r, sd);
        nvec++; if (s !== 1'b1) begin nmis++; $display("FAIL forced_next_sof: got %b want 1", s); end
        nvec++; if ({desc_ncl, desc_err} !== {11'd1, 1'b0}) begin nmis++; $display("FAIL forced_next_desc: got %0d/%b want 1/0", desc_ncl, desc_err); end
        pop_one();
    endtask

    task automatic test_push_pop_reset();
        logic s, e, r;
        logic [511:0] sd;
        drive(mk_cl(1'b1, 10'd7, tb_seq), 1'b1, s, e, r, sd);
        drive(mk_cl(1'b1, 10'd8, tb_seq), 1'b1, s, e, r, sd);
        sink_data  = mk_cl(1'b1, 10'd9, tb_seq);
        sink_valid = 1'b1;
        desc_ready = 1'b1;
        @(posedge clk); #1;
        sink_valid = 1'b0;
        desc_ready = 1'b0;
        tb_seq = tb_seq + 4'd1;
        nvec++; if (desc_len !== 16'd8) begin nmis++; $display("FAIL pp_head: got %0d want 8", desc_len); end
        pop_one();
        nvec++; if ({desc_valid, desc_len} !== {1'b1, 16'd9}) begin nmis++; $display("FAIL pp_second: got %b/%0d want 1/9", desc_valid, desc_len); end
        pop_one();
        nvec++; if (desc_valid !== 1'b0) begin nmis++; $display("FAIL pp_count2: got %b want 0", desc_valid); end
        // Leave one descriptor queued, then reset on beat 2 of a 4-beat frame.
        drive(mk_cl(1'b1, 10'd2, tb_seq), 1'b1, s, e, r, sd);
        drive(mk_cl(1'b0, 10'd4, tb_seq), 1'b0, s, e, r, sd);
        drive(mk_cl(1'b0, 10'd4, tb_seq), 1'b0, s, e, r, sd);
        rst_sync = 1'b1;
        #1;
        nvec++; if (sink_ready !== 1'b0) begin nmis++; $display("FAIL midrst_ready: got %b want 0", sink_ready); end
        @(posedge clk); #1;
        nvec++; if ({desc_valid, frm_cnt, err_cnt} !== 33'd0) begin nmis++; $display("FAIL midrst_state: got %b/%0d/%0d want 0/0/0", desc_valid, frm_cnt, err_cnt); end
        rst_sync = 1'b0;
        tb_seq = 4'd0;
        #1;
        nvec++; if (sink_ready !== 1'b1) begin nmis++; $display("FAIL midrst_release: got %b want 1", sink_ready); end
        drive(mk_cl(1'b1, 10'd3, tb_seq), 1'b1, s, e, r, sd);
        nvec++; if (s !== 1'b1) begin nmis++; $display("FAIL midrst_sof: got %b want 1", s); end
        nvec++; if ({desc_len, desc_ncl, frm_cnt} !== {16'd3, 11'd1, 16'd1}) begin nmis++; $display("FAIL midrst_desc: got %0d/%0d/%0d want 3/1/1", desc_len, desc_ncl, frm_cnt); end
        pop_one();
    endtask

    task automatic test_overflow();
        logic s, e, r;
        logic [511:0] sd;
        // 66 x 1023 = 67518 exceeds 65535 on beat 65.
        for (int i = 1; i <= 66; i++)
            drive(mk_cl(i == 66, 10'd1023, tb_seq), i == 66, s, e, r, sd);
        nvec++; if ({desc_len, desc_ncl, desc_err} !== {16'hFFFF, 11'd66, 1'b1}) begin nmis++; $display("FAIL ovf_desc: got %0d/%0d/%b want 65535/66/1", desc_len, desc_ncl, desc_err); end
        nvec++; if ({frm_cnt, err_cnt} !== {16'd2, 16'd1}) begin nmis++; $display("FAIL ovf_cnt: got %0d/%0d want 2/1", frm_cnt, err_cnt); end
        pop_one();
    endtask

`ifdef CL_SEQ_CHK_EN
    task automatic seq_beat(input logic [511:0] d, output logic se);
        sink_data  = d;
        sink_valid = 1'b1;
        #1;
        se = seq_err;
        @(posedge clk); #1;
        sink_valid = 1'b0;
    endtask

    task automatic test_seq_chk();
        logic se0, se1, se3, se4, sx;
        rst_sync = 1'b1;
        @(posedge clk); #1;
        rst_sync = 1'b0;
        nvec++; if (seq_err !== 1'b0) begin nmis++; $display("FAIL seq_rst: got %b want 0", seq_err); end
        seq_beat(mk_cl(1'b1, 10'd1, 4'd0), se0);
        seq_beat(mk_cl(1'b0, 10'd2, 4'd1), se1);
        seq_beat(mk_cl(1'b1, 10'd2, 4'd9), sx);
        seq_beat(mk_cl(1'b1, 10'd4, 4'd3), se3);
        seq_beat(mk_cl(1'b1, 10'd5, 4'd4), se4);
        nvec++; if ({se0, se1, sx, se3, se4} !== 5'b00010) begin nmis++; $display("FAIL seq_pulses: got %b want 00010", {se0, se1, sx, se3, se4}); end
        nvec++; if ({desc_err, desc_len} !== {1'b0, 16'd1}) begin nmis++; $display("FAIL seq_f0: got %b/%0d want 0/1", desc_err, desc_len); end
        pop_one();
        nvec++; if ({desc_err, desc_len} !== {1'b0, 16'd4}) begin nmis++; $display("FAIL seq_f1: got %b/%0d want 0/4", desc_err, desc_len); end
        pop_one();
        nvec++; if ({desc_err, desc_len} !== {1'b1, 16'd4}) begin nmis++; $display("FAIL seq_f3: got %b/%0d want 1/4", desc_err, desc_len); end
        pop_one();
        nvec++; if ({desc_err, desc_len, err_cnt} !== {1'b0, 16'd5, 16'd1}) begin nmis++; $display("FAIL seq_f4: got %b/%0d/%0d want 0/5/1", desc_err, desc_len, err_cnt); end
        pop_one();
    endtask
`endif

    initial begin
        nvec       = 0;
        nmis       = 0;
        tb_seq     = 4'd0;
        rst_sync   = 1'b1;
        sink_valid = 1'b0;
        sink_data  = '0;
        desc_ready = 1'b0;
        test_reset();
        test_multi_cl();
        test_single();
        test_back_to_back();
        test_forced_close();
        test_push_pop_reset();
        test_overflow();
`ifdef CL_SEQ_CHK_EN
        test_seq_chk();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
